rpn_stack_controller: RTL and testbench
=======================================

RPN_STACK_CONTROLLER -- requirements
Module: rpn_stack_controller

Interface
REQ-001 The block SHALL use one clock `clk` and a synchronous, active-high reset `reset`.
REQ-002 Parameter: DATA_W, default 8, operand and result width in bits.
REQ-003 Parameter: TIMEOUT, default 255, maximum cycles to wait for alu_done after alu_start.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 push_btn  input  1  debounced level; its rising edge requests an operand push.
REQ-007 exec_btn  input  1  debounced level; its rising edge requests operator execution.
REQ-008 data_in  input  DATA_W  operand value sampled on an accepted push.
REQ-009 op_code  input  3  operator selection sampled on an accepted exec.
REQ-010 alu_done  input  1  ALU completion strobe, one cycle.
REQ-011 alu_result  input  DATA_W  ALU result, valid while alu_done=1.
REQ-012 alu_op  output  3  latched operator presented to the ALU.
REQ-013 alu_a  output  DATA_W  first operand, the second-from-top entry.
REQ-014 alu_b  output  DATA_W  second operand, the top entry.
REQ-015 alu_start  output  1  one-cycle ALU start pulse.
REQ-016 top  output  DATA_W  current stack entry s0.
REQ-017 depth  output  2  number of valid entries, 0..3.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 err_overflow, err_underflow, err_timeout  output  1 each  sticky error flags.

Function
REQ-020 Stack SHALL be three DATA_W registers s0 (top), s1, s2.
REQ-021 Edge detect: each button SHALL have a prev register; edge = btn & ~prev; prev <= btn every cycle.
REQ-022 States SHALL be IDLE, ISSUE and WAIT; only IDLE accepts edges.
REQ-023 Edges arriving in ISSUE or WAIT SHALL be dropped, not queued.
REQ-024 Push edge in IDLE with depth<3: s2<=s1, s1<=s0, s0<=data_in, depth+1; top SHALL reflect it the cycle after the edge.
REQ-025 Push edge in IDLE with depth=3: stack and depth SHALL be unchanged; err_overflow<=1.
REQ-026 Exec edge in IDLE with depth<2: stack unchanged; err_underflow<=1; remain in IDLE.
REQ-027 Exec edge in IDLE with depth>=2: latch alu_op<=op_code, alu_a<=s1, alu_b<=s0; go to ISSUE.
REQ-028 Simultaneous push and exec edges in IDLE: exec SHALL win and the push SHALL be dropped.
REQ-029 ISSUE lasts exactly one cycle: alu_start=1; clear the wait counter; go to WAIT.
REQ-030 alu_start SHALL be 0 in every state other than ISSUE.
REQ-031 WAIT on alu_done=1 SHALL do all of the following: s0<=alu_result, s1<=s2, s2<=0, depth-1, go to IDLE.
REQ-032 WAIT without alu_done SHALL increment the wait counter.
REQ-033 Timeout: in WAIT, when the counter reaches TIMEOUT with no alu_done: err_timeout<=1, stack and depth unchanged, go to IDLE.
REQ-034 alu_done arriving in IDLE or ISSUE SHALL be ignored.
REQ-035 alu_op, alu_a and alu_b SHALL hold their values from ISSUE until the next accepted exec.
REQ-036 All three error flags SHALL clear on the next accepted push or accepted exec.
REQ-037 The wait counter SHALL be wide enough for TIMEOUT and SHALL never wrap.

Reset
REQ-038 reset=1 at a clock edge SHALL force the following: state=IDLE; s0, s1, s2=0; depth=0; alu_a, alu_b=0; alu_op=0; alu_start=0; busy=0; all error flags=0; wait counter=0.
REQ-039 Reset SHALL also load both prev registers with the current button levels, so a button held through reset produces no edge.
REQ-040 Reset asserted in ISSUE or WAIT SHALL abort the operation; a later alu_done SHALL be ignored.

Verification
REQ-041 Push 0x05 then 0x03 -> top=0x03, depth=2; internal s1=0x05.
REQ-042 Exec with op_code=1 from depth=2 -> alu_start one cycle, alu_a=0x05, alu_b=0x03; alu_done with result 0x08 three cycles later -> top=0x08, depth=1, busy=0.
REQ-043 From depth=3, push 0x7F -> depth stays 3, err_overflow=1; next exec accepted -> err_overflow=0.
REQ-044 From depth=1, exec -> err_underflow=1, alu_start never asserted, stack unchanged.
REQ-045 Exec with alu_done never asserted -> err_timeout=1 exactly TIMEOUT cycles after entering WAIT; depth unchanged.
REQ-046 Push and exec rising in the same cycle at depth=2 -> only exec accepted; push edges during WAIT have no effect; reset mid-WAIT -> depth=0, busy=0 next cycle.

Source files
------------

// File: rtl/rpn_stack_controller_if.sv
// ----------------------------------------------------------------------------
// rpn_stack_controller_if
//   Bundle of the operator-panel and ALU handshake signals of the RPN stack
//   controller.
//   slave  : controller view (buttons/ALU response in, ALU request/status out)
//   master : environment view (drives buttons and ALU response)
//   Signals:
//     push_btn, exec_btn    debounced button levels
//     data_in, op_code      operand / operator sampled on accepted edges
//     alu_done, alu_result  ALU completion strobe and result
//     alu_op, alu_a, alu_b  latched operator and operands
//     alu_start             one-cycle ALU start pulse
//     top, depth, busy      stack status
//     err_*                 sticky error flags
// ----------------------------------------------------------------------------
interface rpn_stack_controller_if #(
    parameter int DATA_W = 8
);
    logic              push_btn;
    logic              exec_btn;
    logic [DATA_W-1:0] data_in;
    logic [2:0]        op_code;
    logic              alu_done;
    logic [DATA_W-1:0] alu_result;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_start;
    logic [DATA_W-1:0] top;
    logic [1:0]        depth;
    logic              busy;
    logic              err_overflow;
    logic              err_underflow;
    logic              err_timeout;

    modport slave (
        input  push_btn, exec_btn, data_in, op_code, alu_done, alu_result,
        output alu_op, alu_a, alu_b, alu_start, top, depth, busy,
               err_overflow, err_underflow, err_timeout
    );

    modport master (
        output push_btn, exec_btn, data_in, op_code, alu_done, alu_result,
        input  alu_op, alu_a, alu_b, alu_start, top, depth, busy,
               err_overflow, err_underflow, err_timeout
    );
endinterface

// File: rtl/rpn_stack_controller.sv
// ----------------------------------------------------------------------------
// rpn_stack_controller
//   Three-entry RPN operand stack with button-driven push/exec and an
//   external multi-cycle ALU handshake (start pulse, done strobe, timeout).
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous active-high reset
//     bus    rpn_stack_controller_if.slave (buttons, ALU handshake, status)
//   Parameters:
//     DATA_W   operand/result width
//     TIMEOUT  cycles spent in WAIT without alu_done before giving up (>= 1)
// ----------------------------------------------------------------------------
module rpn_stack_controller #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    rpn_stack_controller_if.slave    bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Counter holds 0..TIMEOUT; it stops at TIMEOUT so it can never wrap.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic [1:0]        depth_q, depth_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, tmo_q, tmo_d;
    logic              push_prev_q, exec_prev_q;
    logic              push_edge, exec_edge;

    assign push_edge = bus.push_btn & ~push_prev_q;
    assign exec_edge = bus.exec_btn & ~exec_prev_q;

    always_comb begin
        state_d = state_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        depth_d = depth_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        tmo_d   = tmo_q;

        case (state_q)
            ST_IDLE: begin
                // Exec has priority; a coincident push edge is simply lost.
                if (exec_edge) begin
                    if (depth_q >= 2'd2) begin
                        op_d    = bus.op_code;
                        a_d     = s1_q;
                        b_d     = s0_q;
                        ovf_d   = 1'b0;
                        unf_d   = 1'b0;
                        tmo_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end else begin
                        unf_d = 1'b1;
                    end
                end else if (push_edge) begin
                    if (depth_q != 2'd3) begin
                        s2_d    = s1_q;
                        s1_d    = s0_q;
                        s0_d    = bus.data_in;
                        depth_d = depth_q + 2'd1;
                        ovf_d   = 1'b0;
                        unf_d   = 1'b0;
                        tmo_d   = 1'b0;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.alu_done) begin
                    s0_d    = bus.alu_result;
                    s1_d    = s2_q;
                    s2_d    = '0;
                    depth_d = depth_q - 2'd1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // This no-done cycle is the TIMEOUT-th one in WAIT.
                    if (cnt_q >= CNT_LAST) begin
                        tmo_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s0_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            depth_q     <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            // Preload with live levels so a button held through reset
            // does not register as a fresh press.
            push_prev_q <= bus.push_btn;
            exec_prev_q <= bus.exec_btn;
        end else begin
            state_q     <= state_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            depth_q     <= depth_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            tmo_q       <= tmo_d;
            push_prev_q <= bus.push_btn;
            exec_prev_q <= bus.exec_btn;
        end
    end

    assign bus.alu_op        = op_q;
    assign bus.alu_a         = a_q;
    assign bus.alu_b         = b_q;
    assign bus.alu_start     = (state_q == ST_ISSUE);
    assign bus.top           = s0_q;
    assign bus.depth         = depth_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = unf_q;
    assign bus.err_timeout   = tmo_q;

endmodule

// File: tb/tb_rpn_stack_controller.sv
// ----------------------------------------------------------------------------
// tb_rpn_stack_controller
//   Directed plus randomized stimulus against a queue-based stack model.
// ----------------------------------------------------------------------------
module tb_rpn_stack_controller;
    localparam int DW  = 8;
    localparam int TMO = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rpn_stack_controller_if #(.DATA_W(DW)) bus();

    rpn_stack_controller #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: index 0 is the top of stack.
    logic [DW-1:0] m_stk[$];
    logic          m_ovf, m_unf, m_tmo;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_tmo = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        logic [DW-1:0] etop;
        etop = (m_stk.size() > 0) ? m_stk[0] : '0;
        chk({tag, "_top"},   32'(bus.top), 32'(etop));
        chk({tag, "_depth"}, 32'(bus.depth), 32'(m_stk.size()));
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_start"}, 32'(bus.alu_start), 32'd0);
        chk({tag, "_ovf"},   32'(bus.err_overflow), 32'(m_ovf));
        chk({tag, "_unf"},   32'(bus.err_underflow), 32'(m_unf));
        chk({tag, "_tmo"},   32'(bus.err_timeout), 32'(m_tmo));
    endtask

    task automatic do_push(input logic [DW-1:0] v);
        bus.data_in  = v;
        bus.push_btn = 1'b1;
        step();
        if (m_stk.size() < 3) begin
            m_stk.push_front(v);
            m_ovf = 1'b0; m_unf = 1'b0; m_tmo = 1'b0;
        end else begin
            m_ovf = 1'b1;
        end
        chk_state("push");
        bus.push_btn = 1'b0;
        step();
    endtask

    // dly < 0: ALU never answers. both: push edge rises with exec.
    // noise: random push-button activity while waiting.
    task automatic do_exec(input logic [2:0] op, input int dly, input logic [DW-1:0] res,
                           input bit both, input bit noise);
        logic [DW-1:0] ea, eb;
        int n;
        bit acc;
        acc = (m_stk.size() >= 2);
        ea = acc ? m_stk[1] : '0;
        eb = acc ? m_stk[0] : '0;
        bus.op_code  = op;
        bus.data_in  = DW'($urandom);
        bus.exec_btn = 1'b1;
        bus.push_btn = both;
        step();
        bus.exec_btn = 1'b0;
        bus.push_btn = 1'b0;
        if (!acc) begin
            m_unf = 1'b1;
            chk_state("unf");
            step();
            chk("unf_start_later", 32'(bus.alu_start), 32'd0);
            return;
        end
        m_ovf = 1'b0; m_unf = 1'b0; m_tmo = 1'b0;
        chk("issue_start", 32'(bus.alu_start), 32'd1);
        chk("issue_busy",  32'(bus.busy), 32'd1);
        chk("issue_a",     32'(bus.alu_a), 32'(ea));
        chk("issue_b",     32'(bus.alu_b), 32'(eb));
        chk("issue_op",    32'(bus.alu_op), 32'(op));
        chk("issue_errclr", 32'({bus.err_overflow, bus.err_underflow, bus.err_timeout}), 32'd0);
        step();
        chk("wait_start", 32'(bus.alu_start), 32'd0);
        chk("wait_busy",  32'(bus.busy), 32'd1);
        if (dly >= 0) begin
            for (int i = 0; i < dly; i++) begin
                if (noise) bus.push_btn = 1'($urandom);
                step();
                chk("wait_hold_depth", 32'(bus.depth), 32'(m_stk.size()));
                chk("wait_hold_busy",  32'(bus.busy), 32'd1);
            end
            bus.push_btn   = 1'b0;
            bus.alu_done   = 1'b1;
            bus.alu_result = res;
            step();
            bus.alu_done = 1'b0;
            void'(m_stk.pop_front());
            void'(m_stk.pop_front());
            m_stk.push_front(res);
            chk_state("done");
            chk("hold_a", 32'(bus.alu_a), 32'(ea));
            chk("hold_b", 32'(bus.alu_b), 32'(eb));
        end else begin
            n = 0;
            while (bus.busy && n < TMO + 5) begin
                step();
                n++;
            end
            chk("tmo_cycles", 32'(n), 32'(TMO));
            m_tmo = 1'b1;
            chk_state("tmo");
        end
    endtask

    task automatic stray_done();
        bus.alu_done   = 1'b1;
        bus.alu_result = DW'($urandom);
        step();
        bus.alu_done = 1'b0;
        chk_state("stray");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.push_btn   = 1'b0;
        bus.exec_btn   = 1'b0;
        bus.data_in    = '0;
        bus.op_code    = '0;
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        model_reset();
        chk_state("reset");
        chk("reset_a",  32'(bus.alu_a), 32'd0);
        chk("reset_b",  32'(bus.alu_b), 32'd0);
        chk("reset_op", 32'(bus.alu_op), 32'd0);

        // Push 0x05, 0x03; add them with a late result.
        do_push(8'h05);
        do_push(8'h03);
        do_exec(3'd1, 2, 8'h08, 1'b0, 1'b0);

        // Underflow from depth 1, then overflow at depth 3 and clear on exec.
        do_exec(3'd2, 0, 8'h00, 1'b0, 1'b0);
        do_push(8'h11);
        do_push(8'h22);
        do_push(8'h7F);
        do_exec(3'd3, 0, 8'h5A, 1'b0, 1'b0);

        // Timeout keeps the stack; simultaneous push/exec drops the push.
        do_exec(3'd4, -1, 8'h00, 1'b0, 1'b0);
        do_exec(3'd5, 3, 8'hC3, 1'b1, 1'b1);
        stray_done();

        // Reset in the middle of WAIT aborts; later done is ignored.
        do_push(8'h44);
        bus.op_code  = 3'd6;
        bus.exec_btn = 1'b1;
        step();
        bus.exec_btn = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        chk_state("midwait_reset");
        stray_done();

        // A button held through reset is not a press.
        bus.push_btn = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk_state("held_btn");
        bus.push_btn = 1'b0;
        step();

        for (int it = 0; it < 120; it++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 8)
                do_push(DW'($urandom));
            else if (r < 17)
                do_exec(3'($urandom), int'($urandom_range(0, TMO - 1)), DW'($urandom),
                        ($urandom_range(0, 3) == 0), 1'b1);
            else if (r < 19)
                stray_done();
            else
                do_exec(3'($urandom), -1, '0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
